// File: rtl/regfile_dbg_arbiter_if.sv
// Debug requester bundle for the register-file arbiter.
// Request fields go in, ack/err/rdata/busy come back.
interface regfile_dbg_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  ack, err, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, err, rdata, busy
  );
endinterface

// File: rtl/regfile_dbg_arbiter.sv
// Borrows register-file write port and read port 1 for one debug access
// after halting the CPU; returns result with a one-cycle ack.
module regfile_dbg_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_re1,
  input  logic [ADDR_W-1:0] cpu_r1,
  output logic [DATA_W-1:0] cpu_d1,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_re1,
  output logic [ADDR_W-1:0] rf_r1,
  input  logic [DATA_W-1:0] rf_d1,
  output logic              cpu_halt_req,
  input  logic              cpu_halted,
  regfile_dbg_arbiter_if.slave dbg
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              halt_req_q, halt_req_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      halt_req_q  <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      halt_req_q  <= halt_req_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (dbg.req) begin
          state_d     = S_HALT;
          cnt_d       = '0;
          lat_we_d    = dbg.we;
          lat_addr_d  = dbg.addr;
          lat_wdata_d = dbg.wdata;
        end
      end
      S_HALT: begin
        cnt_d = cnt_q + 1'b1;
        if (cpu_halted) begin
          state_d = S_ACCESS;
        end else if (cnt_q == CNT_LIM) begin
          state_d = S_ERR;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        // x0 reads as zero regardless of the file's read path
        if (!lat_we_q) begin
          rdata_d = (lat_addr_q == '0) ? '0 : rf_d1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decode the state being entered.
  always_comb begin
    halt_req_d = (state_d == S_HALT)
              || (state_d == S_ACCESS)
              || (state_d == S_RESP);
    ack_d      = (state_d == S_RESP)
              || (state_d == S_ERR);
    err_d      = (state_d == S_ERR);
    busy_d     = (state_d != S_IDLE);
  end

  always_comb begin
    rf_we    = cpu_we;
    rf_waddr = cpu_waddr;
    rf_wdata = cpu_wdata;
    rf_re1   = cpu_re1;
    rf_r1    = cpu_r1;
    if (state_q == S_ACCESS) begin
      rf_we    = lat_we_q;
      rf_waddr = lat_addr_q;
      rf_wdata = lat_wdata_q;
      rf_re1   = 1'b1;
      rf_r1    = lat_addr_q;
    end
  end

  assign cpu_d1       = rf_d1;
  assign cpu_halt_req = halt_req_q;
  assign dbg.ack      = ack_q;
  assign dbg.err      = err_q;
  assign dbg.rdata    = rdata_q;
  assign dbg.busy     = busy_q;

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Bench for regfile_dbg_arbiter: register-file model plus
// a scoreboard of expected debug responses.
module tb_regfile_dbg_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        cpu_re1;
  logic [4:0]  cpu_r1;
  logic [31:0] cpu_d1;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_re1;
  logic [4:0]  rf_r1;
  logic [31:0] rf_d1;
  logic        cpu_halt_req;
  logic        cpu_halted;
  logic        rf_clr;

  regfile_dbg_arbiter_if #(.ADDR_W(5), .DATA_W(32)) dbg_if ();

  regfile_dbg_arbiter #(
    .ADDR_W(5), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr),
    .cpu_wdata(cpu_wdata), .cpu_re1(cpu_re1),
    .cpu_r1(cpu_r1), .cpu_d1(cpu_d1),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_re1(rf_re1),
    .rf_r1(rf_r1), .rf_d1(rf_d1),
    .cpu_halt_req(cpu_halt_req),
    .cpu_halted(cpu_halted),
    .dbg(dbg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  always_comb begin
    rf_d1 = '0;
    if (rf_r1 != 5'd0) begin
      if (rf_we && rf_waddr == rf_r1) rf_d1 = rf_wdata;
      else rf_d1 = regs[rf_r1];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst && dbg_if.ack) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_err", dbg_if.err, e.err);
        chk("ack_rdata", dbg_if.rdata, e.rdata);
      end
    end
  end

  task automatic push_exp(input logic err,
                          input logic [31:0] rd,
                          input int lat);
    exp_t e;
    e.err   = err;
    e.rdata = rd;
    e.cyc   = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic start_req(input logic we,
                           input logic [4:0] a,
                           input logic [31:0] d);
    dbg_if.req   = 1'b1;
    dbg_if.we    = we;
    dbg_if.addr  = a;
    dbg_if.wdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b0;
    rf_clr       = 1'b1;
    cpu_we       = 1'b0;
    cpu_waddr    = '0;
    cpu_wdata    = '0;
    cpu_re1      = 1'b0;
    cpu_r1       = '0;
    cpu_halted   = 1'b0;
    dbg_if.req   = 1'b0;
    dbg_if.we    = 1'b0;
    dbg_if.addr  = '0;
    dbg_if.wdata = '0;
    idle(3);
    chk("rst_halt_req", cpu_halt_req, 0);
    chk("rst_ack", dbg_if.ack, 0);
    chk("rst_err", dbg_if.err, 0);
    chk("rst_busy", dbg_if.busy, 0);
    chk("rst_rdata", dbg_if.rdata, 0);
    rst    = 1'b1;
    rf_clr = 1'b0;
    idle(2);

    // debug write x5, CPU already halted
    cpu_halted = 1'b1;
    start_req(1'b1, 5'd5, 32'hDEADBEEF);
    push_exp(1'b0, 32'h0, 3);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) dbg_if.req = 1'b0;
      chk("wr_rf_we", rf_we, (k == 2));
      if (k == 2) begin
        chk("wr_rf_waddr", rf_waddr, 5);
        chk("wr_rf_wdata", rf_wdata, 32'hDEADBEEF);
      end
    end
    idle(2);
    cpu_re1 = 1'b1;
    cpu_r1  = 5'd5;
    #1;
    chk("cpu_rd_x5", cpu_d1, 32'hDEADBEEF);
    chk("cpu_rd_re1", rf_re1, 1);
    cpu_re1 = 1'b0;

    // preload x7, then read it with a 4-cycle halt delay
    @(negedge clk);
    cpu_we    = 1'b1;
    cpu_waddr = 5'd7;
    cpu_wdata = 32'h12345678;
    @(negedge clk);
    cpu_we     = 1'b0;
    cpu_halted = 1'b0;
    cpu_re1    = 1'b1;
    cpu_r1     = 5'd9;
    start_req(1'b0, 5'd7, 32'h0);
    push_exp(1'b0, 32'h12345678, 7);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) dbg_if.req = 1'b0;
      if (k <= 4) begin
        chk("rd_halt_req", cpu_halt_req, 1);
        chk("rd_pass_r1", rf_r1, 9);
        chk("rd_pass_we", rf_we, 0);
      end
      if (k == 5) cpu_halted = 1'b1;
      if (k == 6) chk("rd_access_r1", rf_r1, 7);
    end
    cpu_re1 = 1'b0;
    idle(2);

    // timeout: halted never rises
    cpu_halted = 1'b0;
    start_req(1'b1, 5'd3, 32'h1111);
    push_exp(1'b1, 32'h12345678, 9);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) dbg_if.req = 1'b0;
      chk("to_no_we", rf_we, 0);
      chk("to_halt_req", cpu_halt_req, (k < 9));
    end
    idle(2);

    // register 0 write then read
    cpu_halted = 1'b1;
    start_req(1'b1, 5'd0, 32'hFFFFFFFF);
    push_exp(1'b0, 32'h12345678, 3);
    @(negedge clk);
    dbg_if.req = 1'b0;
    idle(3);
    start_req(1'b0, 5'd0, 32'h0);
    push_exp(1'b0, 32'h0, 3);
    @(negedge clk);
    dbg_if.req = 1'b0;
    idle(3);

    // back-to-back reads with req held
    start_req(1'b0, 5'd7, 32'h0);
    push_exp(1'b0, 32'h12345678, 3);
    push_exp(1'b0, 32'hDEADBEEF, 7);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) dbg_if.addr = 5'd5;
      if (k == 5) dbg_if.req = 1'b0;
      chk("b2b_busy", dbg_if.busy, (k != 4));
    end
    idle(2);

    // asynchronous reset in the middle of HALT
    cpu_halted = 1'b0;
    start_req(1'b1, 5'd9, 32'hABCD);
    @(negedge clk);
    dbg_if.req = 1'b0;
    @(negedge clk);
    chk("pre_rst_halt_req", cpu_halt_req, 1);
    rst = 1'b0;
    #1;
    chk("arst_halt_req", cpu_halt_req, 0);
    chk("arst_busy", dbg_if.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    chk("arst_rdata", dbg_if.rdata, 0);
    chk("arst_no_wr", regs[9], 0);
    cpu_halted = 1'b1;
    start_req(1'b0, 5'd7, 32'h0);
    push_exp(1'b0, 32'h12345678, 3);
    @(negedge clk);
    dbg_if.req = 1'b0;
    idle(5);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
